// File: rtl/mac_t_frame_enq_if.sv
// Byte-wide frame stream from the switch fabric into the enqueue stage.
interface mac_t_frame_enq_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/mac_t_frame_enq.sv
// GMII transmit MAC enqueue stage: buffers the 14-byte header, classifies the
// frame by EtherType, then streams it into the TTE or normal data FIFO and
// closes it with a length word in the matching pointer FIFO.
module mac_t_frame_enq #(
  parameter logic [15:0] TTE_TYPE = 16'h891D,
  parameter int unsigned MIN_LEN  = 14,
  parameter int unsigned MAX_LEN  = 1518,
  parameter int unsigned FIFO_CAP = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  mac_t_frame_enq_if.slave        fab,
  output logic [7:0]              data_fifo_din,
  output logic                    data_fifo_wr,
  input  logic [11:0]             data_fifo_depth,
  output logic [15:0]             ptr_fifo_din,
  output logic                    ptr_fifo_wr,
  input  logic                    ptr_fifo_full,
  output logic [7:0]              tdata_fifo_din,
  output logic                    tdata_fifo_wr,
  input  logic [11:0]             tdata_fifo_depth,
  output logic [15:0]             tptr_fifo_din,
  output logic                    tptr_fifo_wr,
  input  logic                    tptr_fifo_full,
  output logic [15:0]             runt_cnt,
  output logic [15:0]             trunc_cnt,
  output logic [15:0]             tte_cnt
);

  // Depth at or below this leaves room for a maximum-size frame.
  localparam logic [11:0] SPACE_MAX = 12'(FIFO_CAP - 1 - MAX_LEN);
  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
  localparam logic [3:0]  HDR_LAST  = 4'(MIN_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StHdr, StCheck, StFlush, StPass, StDiscard, StPtr
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [3:0]  flush_idx_q, flush_idx_d;
  logic        is_tte_q, is_tte_d;
  logic        last_seen_q, last_seen_d;
  logic        ready_q, ready_d;
  logic [7:0]  hdr_q [MIN_LEN];

  logic        accept;
  logic        space;
  logic        hdr_wr;
  logic [3:0]  hdr_idx;
  logic        byte_wr;
  logic [7:0]  byte_val;
  logic        ptr_wr;
  logic        runt_inc, trunc_inc, tte_inc;

  assign accept       = fab.in_valid & ready_q;
  assign fab.in_ready = ready_q;
  assign space        = is_tte_q ? (!tptr_fifo_full && tdata_fifo_depth <= SPACE_MAX)
                                 : (!ptr_fifo_full && data_fifo_depth <= SPACE_MAX);

  // Next-state, datapath strobes and counter increments.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    flush_idx_d = flush_idx_q;
    is_tte_d    = is_tte_q;
    last_seen_d = last_seen_q;
    hdr_wr      = 1'b0;
    hdr_idx     = 4'd0;
    byte_wr     = 1'b0;
    byte_val    = 8'h00;
    ptr_wr      = 1'b0;
    runt_inc    = 1'b0;
    trunc_inc   = 1'b0;
    tte_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_wr      = 1'b1;
          len_d       = 11'd1;
          last_seen_d = 1'b0;
          if (fab.in_last) runt_inc = 1'b1;
          else             state_d  = StHdr;
        end
      end
      StHdr: begin
        if (accept) begin
          hdr_wr  = 1'b1;
          hdr_idx = len_q[3:0];
          len_d   = len_q + 11'd1;
          if (len_q + 11'd1 < MIN_LEN_W) begin
            if (fab.in_last) begin
              runt_inc = 1'b1;
              state_d  = StIdle;
            end
          end else begin
            // Last EtherType byte is on the bus this cycle, not yet in hdr_q.
            is_tte_d    = ({hdr_q[12], fab.in_data} == TTE_TYPE);
            last_seen_d = fab.in_last;
            state_d     = StCheck;
          end
        end
      end
      StCheck: begin
        if (space) begin
          flush_idx_d = 4'd0;
          state_d     = StFlush;
        end
      end
      StFlush: begin
        byte_wr     = 1'b1;
        byte_val    = hdr_q[flush_idx_q];
        flush_idx_d = flush_idx_q + 4'd1;
        if (flush_idx_q == HDR_LAST) state_d = last_seen_q ? StPtr : StPass;
      end
      StPass: begin
        if (accept) begin
          byte_wr  = 1'b1;
          byte_val = fab.in_data;
          len_d    = len_q + 11'd1;
          if (fab.in_last) begin
            state_d = StPtr;
          end else if (len_q + 11'd1 == MAX_LEN_W) begin
            trunc_inc = 1'b1;
            state_d   = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (accept && fab.in_last) state_d = StPtr;
      end
      StPtr: begin
        ptr_wr  = 1'b1;
        tte_inc = is_tte_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StIdle, StHdr, StPass, StDiscard: ready_d = 1'b1;
      default:                          ready_d = 1'b0;
    endcase
  end

  // Control state and registered FIFO write ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      flush_idx_q    <= '0;
      is_tte_q       <= 1'b0;
      last_seen_q    <= 1'b0;
      ready_q        <= 1'b0;
      data_fifo_wr   <= 1'b0;
      data_fifo_din  <= '0;
      tdata_fifo_wr  <= 1'b0;
      tdata_fifo_din <= '0;
      ptr_fifo_wr    <= 1'b0;
      ptr_fifo_din   <= '0;
      tptr_fifo_wr   <= 1'b0;
      tptr_fifo_din  <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      flush_idx_q    <= flush_idx_d;
      is_tte_q       <= is_tte_d;
      last_seen_q    <= last_seen_d;
      ready_q        <= ready_d;
      data_fifo_wr   <= byte_wr & !is_tte_q;
      data_fifo_din  <= (byte_wr & !is_tte_q) ? byte_val : 8'h00;
      tdata_fifo_wr  <= byte_wr & is_tte_q;
      tdata_fifo_din <= (byte_wr & is_tte_q) ? byte_val : 8'h00;
      ptr_fifo_wr    <= ptr_wr & !is_tte_q;
      ptr_fifo_din   <= (ptr_wr & !is_tte_q) ? {5'b0, len_q} : 16'h0000;
      tptr_fifo_wr   <= ptr_wr & is_tte_q;
      tptr_fifo_din  <= (ptr_wr & is_tte_q) ? {5'b0, len_q} : 16'h0000;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runt_cnt  <= '0;
      trunc_cnt <= '0;
      tte_cnt   <= '0;
    end else begin
      if (runt_inc && runt_cnt != 16'hFFFF)   runt_cnt  <= runt_cnt + 16'd1;
      if (trunc_inc && trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
      if (tte_inc && tte_cnt != 16'hFFFF)     tte_cnt   <= tte_cnt + 16'd1;
    end
  end

  // Header capture; contents only matter once the header is complete.
  always_ff @(posedge clk) begin
    if (hdr_wr) hdr_q[hdr_idx] <= fab.in_data;
  end

endmodule

// File: tb/tb_mac_t_frame_enq.sv
// Directed bench for mac_t_frame_enq: captures every FIFO write into queues and
// compares them with an expected stream built from the frames sent.
module tb_mac_t_frame_enq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_fifo_din, tdata_fifo_din;
  logic        data_fifo_wr, tdata_fifo_wr, ptr_fifo_wr, tptr_fifo_wr;
  logic [15:0] ptr_fifo_din, tptr_fifo_din;
  logic [11:0] data_fifo_depth = 12'd0;
  logic [11:0] tdata_fifo_depth = 12'd0;
  logic        ptr_fifo_full = 1'b0;
  logic        tptr_fifo_full = 1'b0;
  logic [15:0] runt_cnt, trunc_cnt, tte_cnt;

  int cmp = 0;
  int fails = 0;
  int multi_wr = 0;

  logic [15:0] nq[$], tq[$], npq[$], tpq[$];
  logic [15:0] exp_n[$], exp_t[$], exp_np[$], exp_tp[$];

  mac_t_frame_enq_if fab ();

  mac_t_frame_enq dut (
    .clk              (clk),
    .rst              (rst),
    .fab              (fab),
    .data_fifo_din    (data_fifo_din),
    .data_fifo_wr     (data_fifo_wr),
    .data_fifo_depth  (data_fifo_depth),
    .ptr_fifo_din     (ptr_fifo_din),
    .ptr_fifo_wr      (ptr_fifo_wr),
    .ptr_fifo_full    (ptr_fifo_full),
    .tdata_fifo_din   (tdata_fifo_din),
    .tdata_fifo_wr    (tdata_fifo_wr),
    .tdata_fifo_depth (tdata_fifo_depth),
    .tptr_fifo_din    (tptr_fifo_din),
    .tptr_fifo_wr     (tptr_fifo_wr),
    .tptr_fifo_full   (tptr_fifo_full),
    .runt_cnt         (runt_cnt),
    .trunc_cnt        (trunc_cnt),
    .tte_cnt          (tte_cnt)
  );

  always #5 clk = ~clk;

  // Capture FIFO writes away from the active edge.
  always @(negedge clk) begin
    if ((3'(data_fifo_wr) + 3'(tdata_fifo_wr) + 3'(ptr_fifo_wr) + 3'(tptr_fifo_wr)) > 3'd1)
      multi_wr++;
    if (data_fifo_wr)  nq.push_back({8'h00, data_fifo_din});
    if (tdata_fifo_wr) tq.push_back({8'h00, tdata_fifo_din});
    if (ptr_fifo_wr)   npq.push_back(ptr_fifo_din);
    if (tptr_fifo_wr)  tpq.push_back(tptr_fifo_din);
  end

  function automatic logic [7:0] pat(input int s, input int i, input logic [15:0] et);
    if (i == 12) return et[15:8];
    if (i == 13) return et[7:0];
    return 8'(s * 7 + i * 13);
  endfunction

  function automatic int count_diff(input logic [15:0] a[$], input logic [15:0] b[$]);
    int d = 0;
    int n = (a.size() > b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) begin
      if (i >= a.size() || i >= b.size()) d++;
      else if (a[i] !== b[i]) d++;
    end
    return d;
  endfunction

  // Reference model: what a frame should leave behind in the FIFOs.
  task automatic exp_push(input int n, input logic [15:0] et, input int s);
    int m;
    if (n < 14) return;
    m = (n > 1518) ? 1518 : n;
    for (int i = 0; i < m; i++) begin
      if (et == 16'h891D) exp_t.push_back({8'h00, pat(s, i, et)});
      else                exp_n.push_back({8'h00, pat(s, i, et)});
    end
    if (et == 16'h891D) exp_tp.push_back(16'(m));
    else                exp_np.push_back(16'(m));
  endtask

  task automatic clr();
    nq.delete(); tq.delete(); npq.delete(); tpq.delete();
    exp_n.delete(); exp_t.delete(); exp_np.delete(); exp_tp.delete();
  endtask

  // Present one byte and hold it until accepted; returns 1 on timeout.
  task automatic drive_byte(input logic [7:0] d, input logic last, output int to);
    int w = 0;
    fab.in_valid = 1'b1;
    fab.in_data  = d;
    fab.in_last  = last;
    while (fab.in_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    to = (w >= 3000) ? 1 : 0;
    if (to == 0) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [15:0] et, input int s, input int gap,
                            output int to);
    int t;
    to = 0;
    exp_push(n, et, s);
    for (int i = 0; i < n; i++) begin
      drive_byte(pat(s, i, et), (i == n - 1), t);
      to += t;
      if (t != 0) break;
      if (gap > 0) begin
        fab.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    fab.in_valid = 1'b0;
    fab.in_last  = 1'b0;
    fab.in_data  = 8'h00;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cmp++;
    if (fab.in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b want 0", fab.in_ready);
    end
    cmp++;
    if ({data_fifo_wr, tdata_fifo_wr, ptr_fifo_wr, tptr_fifo_wr} !== 4'b0 ||
        {data_fifo_din, tdata_fifo_din, ptr_fifo_din, tptr_fifo_din} !== 48'h0) begin
      fails++; $display("FAIL reset_outputs: wr %b%b%b%b not all zero or din nonzero",
                        data_fifo_wr, tdata_fifo_wr, ptr_fifo_wr, tptr_fifo_wr);
    end
    cmp++;
    if ({runt_cnt, trunc_cnt, tte_cnt} !== 48'h0) begin
      fails++; $display("FAIL reset_counters: got %h %h %h want 0", runt_cnt, trunc_cnt, tte_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp++;
    if (fab.in_ready !== 1'b1) begin
      fails++; $display("FAIL idle_ready: got %b want 1", fab.in_ready);
    end
  endtask

  task automatic test_normal_60();
    int to;
    clr();
    send_frame(60, 16'h0800, 1, 0, to);
    settle();
    cmp++;
    if (to !== 0 || nq.size() !== 60 || tq.size() !== 0 || tpq.size() !== 0) begin
      fails++; $display("FAIL normal60_counts: n=%0d t=%0d tp=%0d to=%0d want 60 0 0 0",
                        nq.size(), tq.size(), tpq.size(), to);
    end
    cmp++;
    if (npq.size() !== 1 || npq[0] !== 16'h003C) begin
      fails++; $display("FAIL normal60_ptr: got %0d entries want one 003c", npq.size());
    end
    cmp++;
    if (count_diff(nq, exp_n) !== 0) begin
      fails++; $display("FAIL normal60_bytes: %0d differing bytes want 0", count_diff(nq, exp_n));
    end
  endtask

  task automatic test_tte_300();
    int to;
    clr();
    send_frame(300, 16'h891D, 2, 0, to);
    settle();
    cmp++;
    if (to !== 0 || tq.size() !== 300 || nq.size() !== 0 || npq.size() !== 0) begin
      fails++; $display("FAIL tte300_counts: t=%0d n=%0d np=%0d want 300 0 0",
                        tq.size(), nq.size(), npq.size());
    end
    cmp++;
    if (tpq.size() !== 1 || tpq[0] !== 16'h012C) begin
      fails++; $display("FAIL tte300_ptr: got %0d entries want one 012c", tpq.size());
    end
    cmp++;
    if (count_diff(tq, exp_t) !== 0) begin
      fails++; $display("FAIL tte300_bytes: %0d differing bytes want 0", count_diff(tq, exp_t));
    end
    cmp++;
    if (tte_cnt !== 16'd1) begin
      fails++; $display("FAIL tte300_cnt: got %0d want 1", tte_cnt);
    end
  endtask

  task automatic test_runt();
    int to;
    clr();
    send_frame(10, 16'h0800, 3, 0, to);
    settle();
    cmp++;
    if (nq.size() + tq.size() + npq.size() + tpq.size() !== 0) begin
      fails++; $display("FAIL runt_writes: got %0d writes want 0",
                        nq.size() + tq.size() + npq.size() + tpq.size());
    end
    cmp++;
    if (runt_cnt !== 16'd1) begin
      fails++; $display("FAIL runt_cnt: got %0d want 1", runt_cnt);
    end
    send_frame(20, 16'h0800, 4, 0, to);
    settle();
    cmp++;
    if (to !== 0 || count_diff(nq, exp_n) + count_diff(npq, exp_np) !== 0) begin
      fails++; $display("FAIL runt_next_frame: %0d diffs to=%0d want 0",
                        count_diff(nq, exp_n) + count_diff(npq, exp_np), to);
    end
  endtask

  task automatic test_trunc();
    int to;
    clr();
    send_frame(2000, 16'h0800, 5, 0, to);
    settle();
    cmp++;
    if (to !== 0) begin
      fails++; $display("FAIL trunc_ready: %0d stalled bytes want 0", to);
    end
    cmp++;
    if (nq.size() !== 1518 || npq.size() !== 1 || npq[0] !== 16'h05EE) begin
      fails++; $display("FAIL trunc_len: got %0d bytes, %0d ptrs want 1518 bytes ptr 05ee",
                        nq.size(), npq.size());
    end
    cmp++;
    if (count_diff(nq, exp_n) !== 0 || trunc_cnt !== 16'd1) begin
      fails++; $display("FAIL trunc_data: %0d diffs trunc_cnt=%0d want 0 and 1",
                        count_diff(nq, exp_n), trunc_cnt);
    end
  endtask

  task automatic test_backpressure();
    int to, tt;
    clr();
    exp_push(20, 16'h0800, 6);
    data_fifo_depth = 12'd2600;
    tt = 0;
    for (int i = 0; i < 14; i++) begin
      drive_byte(pat(6, i, 16'h0800), 1'b0, to);
      tt += to;
    end
    fab.in_data = pat(6, 14, 16'h0800);
    repeat (10) @(negedge clk);
    cmp++;
    if (fab.in_ready !== 1'b0 || nq.size() !== 0) begin
      fails++; $display("FAIL bp_hold: ready=%b writes=%0d want 0 0", fab.in_ready, nq.size());
    end
    data_fifo_depth = 12'd2578;
    repeat (4) @(negedge clk);
    cmp++;
    if (nq.size() !== 0 || data_fifo_wr !== 1'b0) begin
      fails++; $display("FAIL bp_2578: writes=%0d want 0", nq.size());
    end
    data_fifo_depth = 12'd2577;
    @(negedge clk);
    @(negedge clk);
    cmp++;
    if (data_fifo_wr !== 1'b1 || data_fifo_din !== pat(6, 0, 16'h0800)) begin
      fails++; $display("FAIL bp_flush_start: wr=%b din=%h want 1 %h",
                        data_fifo_wr, data_fifo_din, pat(6, 0, 16'h0800));
    end
    for (int i = 14; i < 20; i++) begin
      drive_byte(pat(6, i, 16'h0800), (i == 19), to);
      tt += to;
    end
    fab.in_valid = 1'b0;
    fab.in_last  = 1'b0;
    data_fifo_depth = 12'd0;
    settle();
    cmp++;
    if (tt !== 0 || count_diff(nq, exp_n) + count_diff(npq, exp_np) !== 0) begin
      fails++; $display("FAIL bp_frame: %0d diffs to=%0d want 0",
                        count_diff(nq, exp_n) + count_diff(npq, exp_np), tt);
    end
  endtask

  task automatic test_exact14();
    int to;
    clr();
    send_frame(14, 16'h0800, 7, 0, to);
    settle();
    cmp++;
    if (nq.size() !== 14 || npq.size() !== 1 || npq[0] !== 16'h000E) begin
      fails++; $display("FAIL exact14: got %0d bytes %0d ptrs want 14 and ptr 000e",
                        nq.size(), npq.size());
    end
    cmp++;
    if (count_diff(nq, exp_n) !== 0 || runt_cnt !== 16'd1) begin
      fails++; $display("FAIL exact14_data: %0d diffs runt=%0d want 0 1",
                        count_diff(nq, exp_n), runt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int to, tt;
    clr();
    tt = 0;
    send_frame(64, 16'h0800, 8, 2, to);  tt += to;
    send_frame(17, 16'h891D, 9, 0, to);  tt += to;
    send_frame(33, 16'h0800, 10, 1, to); tt += to;
    send_frame(14, 16'h891D, 11, 3, to); tt += to;
    settle();
    cmp++;
    if (tt !== 0 || count_diff(nq, exp_n) + count_diff(tq, exp_t) !== 0) begin
      fails++; $display("FAIL b2b_bytes: %0d diffs to=%0d want 0",
                        count_diff(nq, exp_n) + count_diff(tq, exp_t), tt);
    end
    cmp++;
    if (count_diff(npq, exp_np) + count_diff(tpq, exp_tp) !== 0) begin
      fails++; $display("FAIL b2b_ptrs: %0d diffs want 0",
                        count_diff(npq, exp_np) + count_diff(tpq, exp_tp));
    end
    cmp++;
    if (tte_cnt !== 16'd3) begin
      fails++; $display("FAIL b2b_tte_cnt: got %0d want 3", tte_cnt);
    end
    cmp++;
    if (multi_wr !== 0) begin
      fails++; $display("FAIL single_wr: %0d cycles with several writes want 0", multi_wr);
    end
  endtask

  initial begin
    fab.in_valid = 1'b0;
    fab.in_data  = 8'h00;
    fab.in_last  = 1'b0;
    test_reset();
    test_normal_60();
    test_tte_300();
    test_runt();
    test_trunc();
    test_backpressure();
    test_exact14();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
